noc_inject_arbiter: RTL and testbench

- Clocked round-robin arbiter sharing one router injection port among NREQ core packet sources.
- Each source presents a destination address (4 b) and a payload (7 b), the same split as the core's addressOut/dataOut pair.
- The winning source's pair is packed into one 11-bit flit {addr, data}, registered, and held on the router port until accepted.
- Sits between the core cluster and the local router input.
- Provides one-flit buffering and back-to-back throughput of one flit per cycle.

---
 rtl/noc_inject_arbiter.sv | 96 +++++++++
 tb/tb_noc_inject_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_inject_arbiter.sv
// Round-robin arbiter packing one of NREQ {addr,data} requests into a registered router flit.
// Flit appears 1 cycle after transfer; a stalled flit holds and blocks all grants until out_ready.
module noc_inject_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 4,
  parameter int DW   = 7,
  parameter int CW   = 16,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic                 CLK,
  input  logic                 _RESET,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 out_valid,
  output logic [AW+DW-1:0]     out_flit,
  input  logic                 out_ready,
  output logic [IW-1:0]        grant_id,
  output logic [CW-1:0]        flit_count
);

  logic            out_valid_q, out_valid_d;
  logic [AW+DW-1:0] flit_q, flit_d;
  logic [IW-1:0]   gid_q, gid_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            found;
  logic [IW-1:0]   win;
  logic            free;
  logic            xfer;

  // Rotating priority scan starting at ptr_q, wrapping modulo NREQ.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  assign free = !out_valid_q || out_ready;
  assign xfer = free && found && _RESET;

  always_ff @(posedge CLK) begin
    if (!_RESET) begin
      out_valid_q <= 1'b0;
      flit_q      <= '0;
      gid_q       <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      flit_q      <= flit_d;
      gid_q       <= gid_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  // A new grant overrides the drain, so accept-and-reload never leaves a bubble.
  always_comb begin
    out_valid_d = out_valid_q;
    flit_d      = flit_q;
    gid_d       = gid_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    if (out_valid_q && out_ready) begin
      cnt_d       = cnt_q + CW'(1);
      out_valid_d = 1'b0;
    end
    if (xfer) begin
      out_valid_d = 1'b1;
      flit_d      = {req_addr[int'(win)*AW +: AW], req_data[int'(win)*DW +: DW]};
      gid_d       = win;
      ptr_d       = (int'(win) == NREQ-1) ? '0 : win + IW'(1);
    end
  end

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[win] = 1'b1;
    out_valid  = out_valid_q;
    out_flit   = flit_q;
    grant_id   = gid_q;
    flit_count = cnt_q;
  end

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Vector table plus scoreboard bench for noc_inject_arbiter (NREQ=4, AW=4, DW=7).
module tb_noc_inject_arbiter;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_addr;
  logic [27:0] req_data;
  logic        out_ready;

  logic [3:0]  req_ready,  req_ready4;
  logic        out_valid,  out_valid4;
  logic [10:0] out_flit,   out_flit4;
  logic [1:0]  grant_id,   grant_id4;
  logic [15:0] flit_count;
  logic [3:0]  flit_count4;

  logic [3:0] src_addr [4];
  logic [6:0] src_data [4];

  assign req_addr = {src_addr[3], src_addr[2], src_addr[1], src_addr[0]};
  assign req_data = {src_data[3], src_data[2], src_data[1], src_data[0]};

  always #5 CLK = ~CLK;

  noc_inject_arbiter dut (
    .CLK(CLK), ._RESET(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .out_valid(out_valid),
    .out_flit(out_flit), .out_ready(out_ready), .grant_id(grant_id),
    .flit_count(flit_count)
  );

  noc_inject_arbiter #(.CW(4)) dut4 (
    .CLK(CLK), ._RESET(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready4), .out_valid(out_valid4),
    .out_flit(out_flit4), .out_ready(out_ready), .grant_id(grant_id4),
    .flit_count(flit_count4)
  );

  typedef struct {
    logic [10:0] flit;
    logic [1:0]  id;
  } flit_rec_t;

  typedef struct {
    logic [3:0]  v;
    logic        rdy;
    logic [3:0]  er;
    logic        ov;
    logic [1:0]  gid;
    logic [10:0] flit;
    int          cnt;
  } vec_t;

  flit_rec_t sbq[$];
  int m_ptr = 0;
  int m_cnt = 0;
  int n_checks = 0;
  int n_fail = 0;
  vec_t tbl [29];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // Checks current outputs against the scoreboard, then advances it across the coming edge.
  task automatic sb_cycle(input string tag);
    int g;
    logic [3:0] er;
    flit_rec_t r;
    g  = rr_pick(req_valid, m_ptr);
    er = 4'b0;
    if (rst_n && g >= 0 && (sbq.size() == 0 || out_ready)) er[g] = 1'b1;
    chk({tag, " sb req_ready"}, 32'(req_ready), 32'(er));
    chk({tag, " sb out_valid"}, 32'(out_valid), 32'(sbq.size() != 0));
    chk({tag, " sb flit_count"}, 32'(flit_count), 32'(m_cnt & 16'hFFFF));
    chk({tag, " sb flit_count cw4"}, 32'(flit_count4), 32'(m_cnt & 15));
    if (sbq.size() != 0) begin
      chk({tag, " sb out_flit"}, 32'(out_flit), 32'(sbq[0].flit));
      chk({tag, " sb grant_id"}, 32'(grant_id), 32'(sbq[0].id));
    end
    if (!rst_n) begin
      sbq.delete();
      m_ptr = 0;
      m_cnt = 0;
    end else begin
      if (sbq.size() != 0 && out_ready) begin
        void'(sbq.pop_front());
        m_cnt++;
      end
      if (er != 4'b0) begin
        r.flit = {src_addr[g], src_data[g]};
        r.id   = 2'(g);
        sbq.push_back(r);
        m_ptr = (g + 1) % 4;
      end
    end
  endtask

  task automatic step(input string tag);
    @(negedge CLK);
    sb_cycle(tag);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 4'b0;
    step("rst");
    step("rst");
    rst_n = 1'b1;
  endtask

  initial begin
    // flits: src0 0x505, src1 0x191, src2 0x2AA, src3 0x7FF
    src_addr[0] = 4'hA; src_data[0] = 7'h05;
    src_addr[1] = 4'h3; src_data[1] = 7'h11;
    src_addr[2] = 4'h5; src_data[2] = 7'h2A;
    src_addr[3] = 4'hF; src_data[3] = 7'h7F;

    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 11'h000, 0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 11'h505, 0};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 11'h191, 1};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 11'h2AA, 2};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 11'h7FF, 3};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 11'h505, 4};
    tbl[6]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 11'h191, 5};
    tbl[7]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 11'h2AA, 6};
    tbl[8]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 11'h7FF, 7};
    tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 11'h505, 8};
    tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 11'h000, 9};
    tbl[11] = '{4'b0010, 1'b0, 4'b0010, 1'b0, 2'd0, 11'h000, 9};
    tbl[12] = '{4'b1000, 1'b0, 4'b0000, 1'b1, 2'd1, 11'h191, 9};
    tbl[13] = '{4'b1000, 1'b0, 4'b0000, 1'b1, 2'd1, 11'h191, 9};
    tbl[14] = '{4'b1000, 1'b0, 4'b0000, 1'b1, 2'd1, 11'h191, 9};
    tbl[15] = '{4'b1000, 1'b0, 4'b0000, 1'b1, 2'd1, 11'h191, 9};
    tbl[16] = '{4'b1000, 1'b0, 4'b0000, 1'b1, 2'd1, 11'h191, 9};
    tbl[17] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd1, 11'h191, 9};
    tbl[18] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 11'h7FF, 10};
    tbl[19] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 11'h000, 11};
    tbl[20] = '{4'b0100, 1'b1, 4'b0100, 1'b0, 2'd0, 11'h000, 11};
    tbl[21] = '{4'b1010, 1'b1, 4'b1000, 1'b1, 2'd2, 11'h2AA, 11};
    tbl[22] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd3, 11'h7FF, 12};
    tbl[23] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 11'h191, 13};
    tbl[24] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 11'h000, 14};
    tbl[25] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 11'h000, 14};
    tbl[26] = '{4'b1111, 1'b1, 4'b0100, 1'b0, 2'd0, 11'h000, 14};
    tbl[27] = '{4'b0000, 1'b1, 4'b0010 & 4'b0000, 1'b1, 2'd2, 11'h2AA, 14};
    tbl[28] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 11'h000, 15};

    // Reset held 3 cycles with every source requesting and the router ready.
    rst_n = 1'b0;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("reset req_ready", 32'(req_ready), 32'h0);
      chk("reset out_valid", 32'(out_valid), 32'h0);
      chk("reset flit_count", 32'(flit_count), 32'h0);
      chk("reset out_flit", 32'(out_flit), 32'h0);
      chk("reset grant_id", 32'(grant_id), 32'h0);
      sb_cycle("reset");
      @(posedge CLK);
      #1;
    end
    rst_n = 1'b1;
    @(negedge CLK);
    chk("post-reset grant src0", 32'(req_ready), 32'b0001);
    sb_cycle("post-reset");
    @(posedge CLK);
    #1;
    req_valid = 4'b0;
    step("post-reset drain");

    // Single source 2.
    do_reset();
    req_valid = 4'b0100;
    out_ready = 1'b1;
    @(negedge CLK);
    chk("single req_ready", 32'(req_ready), 32'b0100);
    sb_cycle("single");
    @(posedge CLK);
    #1;
    req_valid = 4'b0;
    @(negedge CLK);
    chk("single out_valid", 32'(out_valid), 32'h1);
    chk("single out_flit", 32'(out_flit), 32'h2AA);
    chk("single grant_id", 32'(grant_id), 32'd2);
    sb_cycle("single");
    @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("single flit_count", 32'(flit_count), 32'd1);
    sb_cycle("single");
    @(posedge CLK);
    #1;

    // Round robin, backpressure, skip and idle-pointer vectors.
    do_reset();
    for (int i = 0; i < 29; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      req_valid = tbl[i].v;
      out_ready = tbl[i].rdy;
      @(negedge CLK);
      chk({tag, " req_ready"}, 32'(req_ready), 32'(tbl[i].er));
      chk({tag, " out_valid"}, 32'(out_valid), 32'(tbl[i].ov));
      chk({tag, " flit_count"}, 32'(flit_count), 32'(tbl[i].cnt));
      if (tbl[i].ov) begin
        chk({tag, " out_flit"}, 32'(out_flit), 32'(tbl[i].flit));
        chk({tag, " grant_id"}, 32'(grant_id), 32'(tbl[i].gid));
      end
      sb_cycle(tag);
      @(posedge CLK);
      #1;
    end

    // Counter wrap: 16 accepted flits bring the 4-bit counter back to zero.
    do_reset();
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) step("wrap");
    req_valid = 4'b0;
    step("wrap drain");
    @(negedge CLK);
    chk("wrap flit_count cw16", 32'(flit_count), 32'd16);
    chk("wrap flit_count cw4", 32'(flit_count4), 32'd0);
    sb_cycle("wrap");
    @(posedge CLK);
    #1;

    // Reset while a flit is stalled: the flit is dropped and priority returns to 0.
    req_valid = 4'b0100;
    out_ready = 1'b0;
    step("full grant");
    req_valid = 4'b0;
    rst_n = 1'b0;
    @(negedge CLK);
    chk("full before reset out_valid", 32'(out_valid), 32'h1);
    sb_cycle("full reset");
    @(posedge CLK);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge CLK);
    chk("dropped out_valid", 32'(out_valid), 32'h0);
    sb_cycle("dropped");
    @(posedge CLK);
    #1;
    req_valid = 4'b1111;
    @(negedge CLK);
    chk("dropped ptr0 grant", 32'(req_ready), 32'b0001);
    sb_cycle("dropped regrant");
    @(posedge CLK);
    #1;
    req_valid = 4'b0;
    @(negedge CLK);
    chk("dropped next flit", 32'(out_flit), 32'h505);
    chk("dropped next grant_id", 32'(grant_id), 32'd0);
    sb_cycle("dropped next");
    @(posedge CLK);
    #1;
    step("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
